// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM/WB pipeline stage.
package mem_stage_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: issues one data-memory access per memop, waits for ack or
// timeout, then produces a single writeback pulse per instruction.
//
//   state | meaning
//   IDLE  | accepting instructions; ALU ops retire next edge
//   WAIT  | memory request outstanding; inputs ignored, request held
module mem_wb_stage
   import mem_stage_pkg::*;
#(
   parameter int BIT_WIDTH      = 32,
   parameter int REG_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [REG_WIDTH-1:0] in_dr,
   input  logic [BIT_WIDTH-1:0] in_alu,
   input  logic [BIT_WIDTH-1:0] in_sr2,
   input  logic                 in_mem_to_reg,
   input  logic                 in_mem_write,
   input  logic                 in_reg_write,
   input  logic [BIT_WIDTH-1:0] in_pc,
   output logic                 stall,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [BIT_WIDTH-1:0] dmem_addr,
   output logic [BIT_WIDTH-1:0] dmem_wdata,
   input  logic                 dmem_ack,
   input  logic [BIT_WIDTH-1:0] dmem_rdata,
   output logic                 wb_valid,
   output logic                 wb_reg_write,
   output logic [REG_WIDTH-1:0] wb_dr,
   output logic [BIT_WIDTH-1:0] wb_data,
   output logic [BIT_WIDTH-1:0] wb_pc,
   output logic                 fault
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     count;
   logic                 memop;
   logic                 timeout_hit;
   logic [REG_WIDTH-1:0] dr_q;
   logic                 reg_write_q;
   logic                 mem_to_reg_q;
   logic [BIT_WIDTH-1:0] pc_q;

   always_comb begin
      memop       = in_mem_to_reg | in_mem_write;
      timeout_hit = (state == WAIT) && (count == CNT_LAST) && !dmem_ack;
      stall       = ((state == IDLE) && in_valid && memop) ||
                    ((state == WAIT) && !dmem_ack && !timeout_hit);
      state_nxt   = state;
      case (state)
         IDLE: if (in_valid && memop) state_nxt = WAIT;
         WAIT: if (dmem_ack || timeout_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         count        <= '0;
         dr_q         <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         pc_q         <= '0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_dr        <= '0;
         wb_data      <= '0;
         wb_pc        <= '0;
         fault        <= 1'b0;
      end else begin
         state    <= state_nxt;
         wb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && memop) begin
                  dmem_req     <= 1'b1;
                  dmem_we      <= in_mem_write;
                  dmem_addr    <= in_alu;
                  dmem_wdata   <= in_sr2;
                  dr_q         <= in_dr;
                  reg_write_q  <= in_reg_write;
                  mem_to_reg_q <= in_mem_to_reg;
                  pc_q         <= in_pc;
                  count        <= '0;
               end else if (in_valid) begin
                  wb_valid     <= 1'b1;
                  wb_data      <= in_alu;
                  wb_dr        <= in_dr;
                  wb_reg_write <= in_reg_write;
                  wb_pc        <= in_pc;
               end
            end
            WAIT: begin
               if (dmem_ack || timeout_hit) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_dr    <= dr_q;
                  wb_pc    <= pc_q;
                  // Stores and timed-out accesses report the address as data.
                  if (dmem_ack && mem_to_reg_q) begin
                     wb_data      <= dmem_rdata;
                     wb_reg_write <= reg_write_q;
                  end else begin
                     wb_data      <= dmem_addr;
                     wb_reg_write <= 1'b0;
                  end
                  if (timeout_hit) fault <= 1'b1;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus pushes expected writebacks,
// a negedge monitor pops and compares them.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_dr;
   logic [31:0] in_alu;
   logic [31:0] in_sr2;
   logic        in_mem_to_reg;
   logic        in_mem_write;
   logic        in_reg_write;
   logic [31:0] in_pc;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [3:0]  wb_dr;
   logic [31:0] wb_data;
   logic [31:0] wb_pc;
   logic        fault;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  dr;
      logic        rw;
      logic [31:0] pc;
      bit          chk_data;
   } wb_t;

   wb_t exp_q[$];

   mem_wb_stage #(.BIT_WIDTH(32), .REG_WIDTH(4), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_dr(in_dr), .in_alu(in_alu),
      .in_sr2(in_sr2), .in_mem_to_reg(in_mem_to_reg), .in_mem_write(in_mem_write),
      .in_reg_write(in_reg_write), .in_pc(in_pc), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dr(wb_dr),
      .wb_data(wb_data), .wb_pc(wb_pc), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] r, input logic w,
                       input logic [31:0] p, input bit cd);
      wb_t e;
      e.data = d; e.dr = r; e.rw = w; e.pc = p; e.chk_data = cd;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic ld, input logic st, input logic rw, input logic [3:0] dr,
                        input logic [31:0] alu, input logic [31:0] sr2, input logic [31:0] pc);
      in_valid = 1'b1; in_mem_to_reg = ld; in_mem_write = st; in_reg_write = rw;
      in_dr = dr; in_alu = alu; in_sr2 = sr2; in_pc = pc;
   endtask

   always @(negedge clk) begin
      if (wb_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_wb_valid", 32'(wb_valid), 32'd0);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            if (e.chk_data) check("wb_data", wb_data, e.data);
            check("wb_dr", 32'(wb_dr), 32'(e.dr));
            check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
            check("wb_pc", wb_pc, e.pc);
         end
      end
   end

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_dr = '0; in_alu = '0; in_sr2 = '0;
      in_mem_to_reg = 1'b0; in_mem_write = 1'b0; in_reg_write = 1'b0; in_pc = '0;
      dmem_ack = 1'b0; dmem_rdata = '0;
      step(); step();
      check("rst_dmem_req", 32'(dmem_req), 0);
      check("rst_dmem_addr", dmem_addr, 0);
      check("rst_wb_valid", 32'(wb_valid), 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_fault", 32'(fault), 0);
      check("rst_stall", 32'(stall), 0);
      rst = 1'b1;
      step();

      // ALU op
      issue(0, 0, 1, 4'd3, 32'h1234, 32'h0, 32'h100);
      #1 check("alu_stall", 32'(stall), 0);
      push(32'h1234, 4'd3, 1'b1, 32'h100, 1);
      step();
      in_valid = 1'b0;
      check("alu_stall_after", 32'(stall), 0);
      step();

      // Load, ack on third stalled cycle; inputs changed during WAIT must be ignored
      issue(1, 0, 1, 4'd5, 32'h40, 32'h0, 32'h104);
      #1 check("ld_stall_idle", 32'(stall), 1);
      push(32'hDEADBEEF, 4'd5, 1'b1, 32'h104, 1);
      step();
      in_alu = 32'h999; in_sr2 = 32'h777;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("ld_stall_wait", 32'(stall), 1);
         check("ld_req", 32'(dmem_req), 1);
         check("ld_addr", dmem_addr, 32'h40);
         check("ld_we", 32'(dmem_we), 0);
         step();
      end
      dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; in_valid = 1'b0;
      #1 check("ld_stall_ack", 32'(stall), 0);
      step();
      dmem_ack = 1'b0;
      check("ld_req_drop", 32'(dmem_req), 0);
      step();

      // Store, ack in first WAIT cycle
      issue(0, 1, 1, 4'd7, 32'h80, 32'hA5A5, 32'h108);
      push(32'h80, 4'd7, 1'b0, 32'h108, 1);
      step();
      in_valid = 1'b0;
      check("st_req", 32'(dmem_req), 1);
      check("st_we", 32'(dmem_we), 1);
      check("st_wdata", dmem_wdata, 32'hA5A5);
      check("st_addr", dmem_addr, 32'h80);
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      check("st_req_drop", 32'(dmem_req), 0);
      step();

      // Ack coincides with final timeout cycle: ack wins
      issue(1, 0, 1, 4'd4, 32'h44, 32'h0, 32'h200);
      push(32'h12345678, 4'd4, 1'b1, 32'h200, 1);
      step();
      in_valid = 1'b0;
      repeat (3) step();
      dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
      #1 check("coinc_stall", 32'(stall), 0);
      step();
      dmem_ack = 1'b0;
      check("coinc_fault", 32'(fault), 0);
      check("coinc_req", 32'(dmem_req), 0);
      step();

      // Timeout: never ack
      issue(1, 0, 1, 4'd2, 32'hC0, 32'h0, 32'h10C);
      push(32'h0, 4'd2, 1'b0, 32'h10C, 0);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("to_req", 32'(dmem_req), 1);
         check("to_stall", 32'(stall), (i < 3) ? 32'd1 : 32'd0);
         step();
      end
      check("to_req_drop", 32'(dmem_req), 0);
      check("to_fault", 32'(fault), 1);
      // Following ALU op completes normally; fault stays sticky
      issue(0, 0, 1, 4'd9, 32'h55, 32'h0, 32'h110);
      push(32'h55, 4'd9, 1'b1, 32'h110, 1);
      step();
      in_valid = 1'b0;
      check("to_fault_sticky", 32'(fault), 1);
      step();

      // Reset in second WAIT cycle, then a late ack
      issue(1, 0, 1, 4'd6, 32'h300, 32'h0, 32'h114);
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("rstw_req", 32'(dmem_req), 0);
      check("rstw_wb_valid", 32'(wb_valid), 0);
      check("rstw_fault", 32'(fault), 0);
      dmem_ack = 1'b1; dmem_rdata = 32'hBAD;
      #1 check("rstw_stall", 32'(stall), 0);
      step();
      dmem_ack = 1'b0;
      check("late_ack_req", 32'(dmem_req), 0);
      check("late_ack_wb_valid", 32'(wb_valid), 0);
      step(); step();

      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
